// File: rtl/xc_malu_pmul_seq_pkg.sv
// Shared MALU definitions: sequencer state encoding and the packed-width priority decode.
package xc_malu_pmul_seq_pkg;

    localparam logic [1:0] PMUL_IDLE = 2'd0;
    localparam logic [1:0] PMUL_LOAD = 2'd1;
    localparam logic [1:0] PMUL_RUN  = 2'd2;
    localparam logic [1:0] PMUL_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = PMUL_IDLE,
        ST_LOAD = PMUL_LOAD,
        ST_RUN  = PMUL_RUN,
        ST_DONE = PMUL_DONE
    } pmul_state_t;

    // Returns one-hot {pw_16, pw_8, pw_4, pw_2}; the narrowest requested width wins.
    function automatic logic [3:0] pw_decode(
        input logic pw_16,
        input logic pw_8,
        input logic pw_4,
        input logic pw_2
    );
        logic [3:0] w_sel;
        if (pw_2) begin
            w_sel = 4'b0001;
        end else if (pw_4) begin
            w_sel = 4'b0010;
        end else if (pw_8) begin
            w_sel = 4'b0100;
        end else if (pw_16) begin
            w_sel = 4'b1000;
        end else begin
            w_sel = 4'b0000;
        end
        return w_sel;
    endfunction

endpackage

// File: rtl/xc_malu_pmul_seq.sv
// Multi-cycle sequencer for the packed multiplier core: latches a request, owns the
// iteration state fed to the core, steps it until completion and returns a registered result.
module xc_malu_pmul_seq
    import xc_malu_pmul_seq_pkg::*;
#(
    parameter logic [5:0] MAX_COUNT = 6'd63
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        carryless,
    input  logic        pw_16,
    input  logic        pw_8,
    input  logic        pw_4,
    input  logic        pw_2,
    output logic        ready,
    output logic [63:0] result,
    output logic        error,
    output logic        busy,
    output logic [31:0] pmul_rs1,
    output logic [31:0] pmul_rs2,
    output logic [5:0]  pmul_count,
    output logic [63:0] pmul_acc,
    output logic [31:0] pmul_arg_0,
    output logic        pmul_carryless,
    output logic        pmul_pw_16,
    output logic        pmul_pw_8,
    output logic        pmul_pw_4,
    output logic        pmul_pw_2,
    input  logic [63:0] pmul_n_acc,
    input  logic [31:0] pmul_n_arg_0,
    input  logic [63:0] pmul_result,
    input  logic        pmul_ready
);

    pmul_state_t r_state;
    logic        r_ready;
    logic        r_error;
    logic        r_err_flag;
    logic [63:0] r_result;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [5:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_arg_0;
    logic        r_carryless;
    logic [3:0]  r_pw;
    logic [3:0]  w_pw_sel;

    assign w_pw_sel = pw_decode(pw_16, pw_8, pw_4, pw_2);

    // Sequencer FSM with all iteration state and registered handshake outputs.
    // ready/error are registered out of DONE, so they appear the cycle after DONE.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_err_flag  <= 1'b0;
            r_result    <= 64'd0;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_count     <= 6'd0;
            r_acc       <= 64'd0;
            r_arg_0     <= 32'd0;
            r_carryless <= 1'b0;
            r_pw        <= 4'd0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_err_flag <= 1'b0;
            r_count    <= 6'd0;
            r_acc      <= 64'd0;
            r_arg_0    <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_rs1       <= rs1;
                        r_rs2       <= rs2;
                        r_carryless <= carryless;
                        r_pw        <= w_pw_sel;
                        r_acc       <= 64'd0;
                        r_arg_0     <= rs2;
                        r_count     <= 6'd0;
                        r_err_flag  <= 1'b0;
                        r_state     <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (pmul_ready) begin
                        r_result <= pmul_result;
                        r_state  <= ST_DONE;
                    end else if (r_count == MAX_COUNT) begin
                        r_result   <= 64'd0;
                        r_err_flag <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_acc   <= pmul_n_acc;
                        r_arg_0 <= pmul_n_arg_0;
                        r_count <= r_count + 6'd1;
                    end
                end
                ST_DONE: begin
                    r_ready    <= 1'b1;
                    r_error    <= r_err_flag;
                    r_err_flag <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready          = r_ready;
    assign error          = r_error;
    assign result         = r_result;
    assign busy           = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign pmul_rs1       = r_rs1;
    assign pmul_rs2       = r_rs2;
    assign pmul_count     = r_count;
    assign pmul_acc       = r_acc;
    assign pmul_arg_0     = r_arg_0;
    assign pmul_carryless = r_carryless;
    assign pmul_pw_16     = r_pw[3];
    assign pmul_pw_8      = r_pw[2];
    assign pmul_pw_4      = r_pw[1];
    assign pmul_pw_2      = r_pw[0];

endmodule

// File: tb/tb_xc_malu_pmul_seq.sv
// Directed self-checking bench for xc_malu_pmul_seq with a behavioural shift-add core model.
module tb_xc_malu_pmul_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        carryless;
    logic        pw_16, pw_8, pw_4, pw_2;
    logic        ready;
    logic [63:0] result;
    logic        error;
    logic        busy;
    logic [31:0] pmul_rs1, pmul_rs2;
    logic [5:0]  pmul_count;
    logic [63:0] pmul_acc;
    logic [31:0] pmul_arg_0;
    logic        pmul_carryless;
    logic        pmul_pw_16, pmul_pw_8, pmul_pw_4, pmul_pw_2;
    logic [63:0] pmul_n_acc;
    logic [31:0] pmul_n_arg_0;
    logic [63:0] pmul_result;
    logic        pmul_ready;

    // 0: stub returning 15 at count 32, 1: real shift-add core, 2: never completes
    int core_mode;
    int n_cmp;
    int n_bad;

    xc_malu_pmul_seq #(.MAX_COUNT(6'd63)) dut (
        .g_clk(clk), .g_resetn(rst_n), .flush(flush), .valid(valid),
        .rs1(rs1), .rs2(rs2), .carryless(carryless),
        .pw_16(pw_16), .pw_8(pw_8), .pw_4(pw_4), .pw_2(pw_2),
        .ready(ready), .result(result), .error(error), .busy(busy),
        .pmul_rs1(pmul_rs1), .pmul_rs2(pmul_rs2), .pmul_count(pmul_count),
        .pmul_acc(pmul_acc), .pmul_arg_0(pmul_arg_0),
        .pmul_carryless(pmul_carryless),
        .pmul_pw_16(pmul_pw_16), .pmul_pw_8(pmul_pw_8),
        .pmul_pw_4(pmul_pw_4), .pmul_pw_2(pmul_pw_2),
        .pmul_n_acc(pmul_n_acc), .pmul_n_arg_0(pmul_n_arg_0),
        .pmul_result(pmul_result), .pmul_ready(pmul_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: one partial product per step, 32 steps, done at count == 32.
    always_comb begin
        logic [63:0] addend;
        addend = 64'd0;
        if (pmul_arg_0[0] && (pmul_count < 6'd32))
            addend = {32'd0, pmul_rs1} << pmul_count;
        pmul_n_acc   = pmul_carryless ? (pmul_acc ^ addend) : (pmul_acc + addend);
        pmul_n_arg_0 = pmul_arg_0 >> 1;
        pmul_ready   = (core_mode != 2) && (pmul_count == 6'd32);
        pmul_result  = (core_mode == 0) ? 64'd15 : pmul_acc;
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cl);
        @(negedge clk);
        rs1 = a; rs2 = b; carryless = cl; valid = 1'b1;
    endtask

    // Waits for ready; lat = edges after the request-sampling edge, -1 on timeout.
    task automatic wait_ready(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n - 1;
                valid = 1'b0;
                break;
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rs1 = 32'd0; rs2 = 32'd0;
        carryless = 1'b0; pw_16 = 1'b0; pw_8 = 1'b0; pw_4 = 1'b0; pw_2 = 1'b0;
        core_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready, error, busy} !== 3'b000 || result !== 64'd0 || pmul_count !== 6'd0 ||
            pmul_acc !== 64'd0 || pmul_arg_0 !== 32'd0 || pmul_rs1 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: rdy/err/busy=%b result=%0d count=%0d acc=%0d arg0=%0d, required all 0",
                     {ready, error, busy}, result, pmul_count, pmul_acc, pmul_arg_0);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_mul32;
        int lat, bad_step, max_cnt;
        logic [5:0] prev;
        core_mode = 0;
        start_op(32'd3, 32'd5, 1'b0);
        lat = -1; bad_step = 0; max_cnt = 0; prev = 6'd0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (busy) begin
                if (pmul_count != prev && pmul_count != prev + 6'd1) bad_step++;
                prev = pmul_count;
                if (int'(pmul_count) > max_cnt) max_cnt = int'(pmul_count);
            end
            if (ready) begin lat = n - 1; valid = 1'b0; break; end
        end
        n_cmp++;
        if (lat !== 35) begin n_bad++; $display("FAIL mul32_latency: got %0d, required 35", lat); end
        n_cmp++;
        if (result !== 64'd15) begin n_bad++; $display("FAIL mul32_result: got %0d, required 15", result); end
        n_cmp++;
        if (bad_step !== 0 || max_cnt !== 32) begin
            n_bad++; $display("FAIL mul32_count: bad steps %0d max %0d, required 0 and 32", bad_step, max_cnt);
        end
        n_cmp++;
        if (error !== 1'b0) begin n_bad++; $display("FAIL mul32_error: got %b, required 0", error); end
    endtask

    task automatic test_carryless;
        int lat, pulses;
        core_mode = 1;
        start_op(32'd3, 32'd3, 1'b1);
        wait_ready(200, lat);
        pulses = (lat >= 0) ? 1 : 0;
        n_cmp++;
        if (result !== 64'd5) begin n_bad++; $display("FAIL clmul_result: got %0d, required 5", result); end
        repeat (6) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        n_cmp++;
        if (pulses !== 1) begin n_bad++; $display("FAIL clmul_pulses: got %0d ready pulses, required 1", pulses); end
    endtask

    task automatic test_flush;
        int lat, seen, rdy_cnt;
        core_mode = 1;
        start_op(32'd5, 32'd5, 1'b0);
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (busy && pmul_count == 6'd4) begin seen = 1; break; end
        end
        n_cmp++;
        if (seen !== 1) begin n_bad++; $display("FAIL flush_reach_count4: got %0d, required 1", seen); end
        flush = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0 || pmul_count !== 6'd0 || pmul_acc !== 64'd0 || pmul_arg_0 !== 32'd0) begin
            n_bad++;
            $display("FAIL flush_state: busy=%b ready=%b count=%0d acc=%0d arg0=%0d, required all 0",
                     busy, ready, pmul_count, pmul_acc, pmul_arg_0);
        end
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) rdy_cnt++;
        end
        n_cmp++;
        if (rdy_cnt !== 0) begin n_bad++; $display("FAIL flush_no_ready: got %0d pulses, required 0", rdy_cnt); end
        start_op(32'd7, 32'd6, 1'b0);
        wait_ready(200, lat);
        n_cmp++;
        if (lat !== 35 || result !== 64'd42) begin
            n_bad++; $display("FAIL flush_next_op: latency %0d result %0d, required 35 and 42", lat, result);
        end
    endtask

    task automatic test_watchdog;
        int lat;
        core_mode = 2;
        start_op(32'd9, 32'd9, 1'b0);
        wait_ready(200, lat);
        n_cmp++;
        if (lat !== 66 || error !== 1'b1) begin
            n_bad++; $display("FAIL watchdog_abort: latency %0d error %b, required 66 and 1", lat, error);
        end
        n_cmp++;
        if (result !== 64'd0) begin n_bad++; $display("FAIL watchdog_result: got %0d, required 0", result); end
        @(posedge clk); #1;
        n_cmp++;
        if (error !== 1'b0 || ready !== 1'b0) begin
            n_bad++; $display("FAIL watchdog_pulse: error %b ready %b, required 0 0", error, ready);
        end
        core_mode = 1;
    endtask

    task automatic test_back_to_back;
        int lat;
        core_mode = 1;
        start_op(32'd10, 32'd11, 1'b0);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (ready) begin lat = n - 1; break; end
        end
        n_cmp++;
        if (lat !== 35 || result !== 64'd110) begin
            n_bad++; $display("FAIL b2b_first: latency %0d result %0d, required 35 and 110", lat, result);
        end
        rs1 = 32'd4; rs2 = 32'd9;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1 || pmul_rs1 !== 32'd4 || pmul_arg_0 !== 32'd9) begin
            n_bad++; $display("FAIL b2b_load: busy %b rs1 %0d arg0 %0d, required 1 4 9", busy, pmul_rs1, pmul_arg_0);
        end
        n_cmp++;
        if (result !== 64'd110) begin n_bad++; $display("FAIL b2b_result_hold: got %0d, required 110", result); end
        wait_ready(200, lat);
        n_cmp++;
        if (lat !== 34 || result !== 64'd36) begin
            n_bad++; $display("FAIL b2b_second: latency %0d result %0d, required 34 and 36", lat, result);
        end
    endtask

    task automatic test_pw_priority;
        core_mode = 1;
        @(negedge clk);
        pw_16 = 1'b1; pw_4 = 1'b1;
        start_op(32'h1234, 32'h55, 1'b1);
        @(posedge clk); #1;
        valid = 1'b0; rs1 = 32'hdead; pw_16 = 1'b0; pw_4 = 1'b0; carryless = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({pmul_pw_16, pmul_pw_8, pmul_pw_4, pmul_pw_2} !== 4'b0010 || pmul_carryless !== 1'b1) begin
            n_bad++; $display("FAIL pw_priority: pw %b cl %b, required 0010 1",
                              {pmul_pw_16, pmul_pw_8, pmul_pw_4, pmul_pw_2}, pmul_carryless);
        end
        n_cmp++;
        if (pmul_rs1 !== 32'h1234) begin n_bad++; $display("FAIL operand_latch: got %h, required 1234", pmul_rs1); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_async_reset;
        core_mode = 1;
        start_op(32'd21, 32'd13, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0 || error !== 1'b0 || result !== 64'd0 || pmul_count !== 6'd0 ||
            pmul_acc !== 64'd0 || pmul_arg_0 !== 32'd0 || pmul_rs1 !== 32'd0 || pmul_rs2 !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy %b ready %b result %0d count %0d acc %0d rs1 %0d, required all 0",
                     busy, ready, result, pmul_count, pmul_acc, pmul_rs1);
        end
        valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_idle: busy %b, required 0", busy); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mul32();
        test_carryless();
        test_flush();
        test_watchdog();
        test_back_to_back();
        test_pw_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
